// File: rtl/ltl_nfa_monitor_pkg.sv
// Shared types and helpers for the homogeneous-NFA LTL monitor.
//   start_type_e : per-STE start behaviour (none / start-of-data / every symbol)
//   CFG_*        : cfg_kind encodings for the configuration write port
//   clog2_min1   : ceil(log2(n)), never below 1, for index widths
package ltl_mon_pkg;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_SOD  = 2'd1,
    ST_ALL  = 2'd2
  } start_type_e;

  localparam logic [1:0] CFG_MATCH = 2'd0;
  localparam logic [1:0] CFG_ADJ   = 2'd1;
  localparam logic [1:0] CFG_START = 2'd2;
  localparam logic [1:0] CFG_RPT   = 2'd3;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ltl_nfa_monitor_if.sv
// Symbol-stream and report-stream bundle of the NFA monitor.
//   sym_valid/sym_ready/symbol          : trace tap -> monitor
//   rpt_valid/rpt_ready/rpt_vec/offset  : monitor report FIFO head -> consumer
// master = trace source / report consumer, slave = monitor.
interface ltl_nfa_monitor_if #(
  parameter int N_STATES = 16,
  parameter int SYM_W    = 8,
  parameter int OFF_W    = 32
);
  logic                sym_valid;
  logic                sym_ready;
  logic [SYM_W-1:0]    symbol;
  logic                rpt_valid;
  logic                rpt_ready;
  logic [N_STATES-1:0] rpt_vec;
  logic [OFF_W-1:0]    rpt_offset;

  modport master (output sym_valid, symbol, rpt_ready,
                  input  sym_ready, rpt_valid, rpt_vec, rpt_offset);
  modport slave  (input  sym_valid, symbol, rpt_ready,
                  output sym_ready, rpt_valid, rpt_vec, rpt_offset);
endinterface

// File: rtl/ltl_nfa_monitor_rpt_fifo.sv
// First-word-fall-through report FIFO.
//   clk, reset (async high), clr (sync flush)
//   push/din  : write side; ignored when full
//   pop/dout  : read side; dout shows the head whenever !empty
//   empty, count
module ltl_mon_rpt_fifo #(
  parameter  int W     = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset)
    if (reset || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end

  always_ff @(posedge clk)
    if (do_push && !clr) mem[wr_ptr] <= din;
endmodule

// File: rtl/ltl_nfa_monitor.sv
// Runtime-programmable homogeneous-NFA LTL monitor.
//   clk, reset (async high)
//   run    : 1 consume symbols, 0 freeze state and allow config writes
//   clear  : sync soft clear of active vector, FIFO, offset; re-arms SOD
//   bus    : symbol stream in, report stream out (ltl_nfa_monitor_if.slave)
//   cfg_*  : config write port (match column / adjacency row / start / mask)
//   active : registered active-STE vector
//   rpt_drop : sticky, a report was lost to a clear
// LTL_MON_OFFSET_EN: when defined, a saturating symbol offset counter is kept
// and carried with each report; otherwise rpt_offset is 0.
module ltl_nfa_monitor
  import ltl_mon_pkg::*;
#(
  parameter  int N_STATES  = 16,
  parameter  int SYM_W     = 8,
  parameter  int RPT_DEPTH = 8,
  parameter  int OFF_W     = 32,
  localparam int IDX_W     = (SYM_W > clog2_min1(N_STATES)) ? SYM_W : clog2_min1(N_STATES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  clear,
  ltl_nfa_monitor_if.slave      bus,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_kind,
  input  logic [IDX_W-1:0]      cfg_index,
  input  logic [2*N_STATES-1:0] cfg_data,
  output logic [N_STATES-1:0]   active,
  output logic                  rpt_drop
);
  localparam int N_SYM = 1 << SYM_W;
  localparam int SW    = clog2_min1(N_STATES);
  localparam int CW    = ((RPT_DEPTH <= 2) ? 1 : $clog2(RPT_DEPTH)) + 1;
`ifdef LTL_MON_OFFSET_EN
  localparam int RW    = N_STATES + OFF_W;
`else
  localparam int RW    = N_STATES;
`endif

  logic [N_STATES-1:0]      match_tbl [N_SYM];
  logic [N_STATES-1:0]      adj [N_STATES];   // adj[src][dst]
  logic [N_STATES-1:0][1:0] st;
  logic [N_STATES-1:0]      rpt_mask;
  logic                     sod;

  logic [N_STATES-1:0] sym_match, next_active, hit_vec;
  logic                accept, hit, push, fifo_full, fifo_empty;
  logic [CW-1:0]       fifo_cnt;
  logic [RW-1:0]       push_data, head;

  assign fifo_full     = (fifo_cnt == CW'(RPT_DEPTH));
  assign bus.sym_ready = run & ~fifo_full;
  assign accept        = bus.sym_valid & bus.sym_ready;
  assign sym_match     = match_tbl[bus.symbol];

  // STE array: enabled by start type or by any active predecessor.
  for (genvar gi = 0; gi < N_STATES; gi++) begin : g_ste
    logic [N_STATES-1:0] adj_col;
    for (genvar gj = 0; gj < N_STATES; gj++) begin : g_col
      assign adj_col[gj] = adj[gj][gi];
    end
    assign next_active[gi] = sym_match[gi] &
                             (st[gi][1] | ((st[gi] == ST_SOD) & sod) | |(active & adj_col));
  end

  assign hit_vec = next_active & rpt_mask;
  assign hit     = |hit_vec;
  assign push    = accept & hit & ~clear;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int s = 0; s < N_SYM; s++)    match_tbl[s] <= '0;
      for (int r = 0; r < N_STATES; r++) adj[r]       <= '0;
      st       <= '0;
      rpt_mask <= '0;
    end else if (cfg_we && !run) begin
      case (cfg_kind)
        CFG_MATCH: if (int'(cfg_index) < N_SYM)
                     match_tbl[cfg_index[SYM_W-1:0]] <= cfg_data[N_STATES-1:0];
        CFG_ADJ:   if (int'(cfg_index) < N_STATES)
                     adj[cfg_index[SW-1:0]] <= cfg_data[N_STATES-1:0];
        CFG_START: st <= cfg_data;
        default:   rpt_mask <= cfg_data[N_STATES-1:0];
      endcase
    end

  // A clear colliding with a would-be push is the only way to lose a report.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      active   <= '0;
      sod      <= 1'b1;
      rpt_drop <= 1'b0;
    end else if (clear) begin
      active   <= '0;
      sod      <= 1'b1;
      rpt_drop <= accept & hit;
    end else if (accept) begin
      active <= next_active;
      sod    <= 1'b0;
    end

`ifdef LTL_MON_OFFSET_EN
  logic [OFF_W-1:0] offset;
  always_ff @(posedge clk or posedge reset)
    if (reset)                        offset <= '0;
    else if (clear)                   offset <= '0;
    else if (accept && offset != '1)  offset <= offset + OFF_W'(1);
  assign push_data      = {hit_vec, offset};
  assign bus.rpt_offset = head[OFF_W-1:0];
`else
  assign push_data      = hit_vec;
  assign bus.rpt_offset = '0;
`endif
  assign bus.rpt_vec   = head[RW-1 -: N_STATES];
  assign bus.rpt_valid = ~fifo_empty;

  ltl_mon_rpt_fifo #(.W(RW), .DEPTH(RPT_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .push  (push),
    .din   (push_data),
    .pop   (bus.rpt_ready),
    .dout  (head),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );
endmodule

// File: tb/tb_ltl_nfa_monitor.sv
// Randomized + directed bench for ltl_nfa_monitor with an in-bench reference model.
module tb_ltl_nfa_monitor;
  localparam int N = 16;
  localparam int D = 8;

  logic        clk = 0;
  logic        reset, run, clear, cfg_we;
  logic [1:0]  cfg_kind;
  logic [7:0]  cfg_index;
  logic [31:0] cfg_data;
  logic [15:0] active;
  logic        rpt_drop;

  ltl_nfa_monitor_if #(.N_STATES(16), .SYM_W(8), .OFF_W(32)) bus ();

  ltl_nfa_monitor #(.N_STATES(16), .SYM_W(8), .RPT_DEPTH(8), .OFF_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .clear(clear), .bus(bus),
    .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_index(cfg_index), .cfg_data(cfg_data),
    .active(active), .rpt_drop(rpt_drop)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed { logic [15:0] vec; logic [31:0] off; } rpt_t;
  logic [15:0] m_match [256];
  logic [15:0] m_adj [16];
  logic [1:0]  m_st [16];
  logic [15:0] m_mask, m_active;
  bit          m_sod, m_drop;
  logic [31:0] m_off;
  rpt_t        m_q[$];

  int vecs = 0, errs = 0, acc_cnt = 0;

  function automatic logic [31:0] exp_off(input logic [31:0] o);
`ifdef LTL_MON_OFFSET_EN
    return o;
`else
    return (o & 32'h0);
`endif
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 256; s++) m_match[s] = '0;
    for (int r = 0; r < 16; r++) begin m_adj[r] = '0; m_st[r] = 2'd0; end
    m_mask = '0; m_active = '0; m_sod = 1; m_drop = 0; m_off = '0;
    m_q.delete();
  endtask

  function automatic logic [15:0] model_next(input logic [7:0] s);
    logic [15:0] nxt = '0;
    for (int i = 0; i < N; i++) begin
      bit started = (m_st[i] >= 2) || (m_st[i] == 1 && m_sod);
      bit pred = 0;
      for (int j = 0; j < N; j++) if (m_active[j] && m_adj[j][i]) pred = 1;
      nxt[i] = m_match[s][i] && (started || pred);
    end
    return nxt;
  endfunction

  task automatic model_edge();
    bit ready = run && (m_q.size() < D);
    bit acc = bus.sym_valid && ready;
    bit pop = (m_q.size() > 0) && bus.rpt_ready;
    logic [15:0] nxt = model_next(bus.symbol);
    bit hit = |(nxt & m_mask);
    rpt_t e;
    if (clear) begin
      m_drop = acc && hit; m_active = '0; m_q.delete(); m_off = '0; m_sod = 1;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        if (hit) begin e.vec = nxt & m_mask; e.off = m_off; m_q.push_back(e); end
        m_active = nxt; m_sod = 0;
        if (m_off != 32'hFFFF_FFFF) m_off++;
      end
    end
    if (cfg_we && !run) begin
      case (cfg_kind)
        2'd0: m_match[cfg_index] = cfg_data[15:0];
        2'd1: if (cfg_index < 16) m_adj[cfg_index[3:0]] = cfg_data[15:0];
        2'd2: for (int i = 0; i < N; i++) m_st[i] = cfg_data[2*i +: 2];
        default: m_mask = cfg_data[15:0];
      endcase
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("sym_ready", 64'(bus.sym_ready), 64'(run && m_q.size() < D));
    check("active", 64'(active), 64'(m_active));
    check("rpt_valid", 64'(bus.rpt_valid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check("rpt_vec", 64'(bus.rpt_vec), 64'(m_q[0].vec));
      check("rpt_offset", 64'(bus.rpt_offset), 64'(exp_off(m_q[0].off)));
    end
    check("rpt_drop", 64'(rpt_drop), 64'(m_drop));
  endtask

  // Called just after a falling edge: counts DUT accepts, clocks DUT and model, compares.
  task automatic step();
    #1;
    if (bus.sym_valid && bus.sym_ready) acc_cnt++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cfg_write(input int kind, input int idx, input logic [31:0] d);
    cfg_we = 1; cfg_kind = 2'(kind); cfg_index = 8'(idx); cfg_data = d;
    step();
    cfg_we = 0;
  endtask

  task automatic send(input logic [7:0] s);
    bus.sym_valid = 1; bus.symbol = s;
    step();
    bus.sym_valid = 0;
  endtask

  task automatic do_clear();
    clear = 1; step(); clear = 0;
  endtask

  initial begin
    reset = 1; run = 0; clear = 0; cfg_we = 0; cfg_kind = 0; cfg_index = 0; cfg_data = 0;
    bus.sym_valid = 0; bus.symbol = 0; bus.rpt_ready = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    reset = 0;
    compare_all();
    check("reset_active", 64'(active), 64'h0);
    check("reset_rpt_valid", 64'(bus.rpt_valid), 64'h0);

    // 1: S0 SOD on 0x00-0x0F, S0->S1, S1 on 0x10, report S1
    for (int s = 0; s < 16; s++) cfg_write(0, s, 32'h0001);
    cfg_write(0, 8'h10, 32'h0002);
    cfg_write(1, 0, 32'h0002);
    cfg_write(2, 0, 32'h0001);
    cfg_write(3, 0, 32'h0002);
    run = 1;
    send(8'h05);
    check("t1_active_a", 64'(active), 64'h0001);
    send(8'h10);
    check("t1_active_b", 64'(active), 64'h0002);
    check("t1_rpt_valid", 64'(bus.rpt_valid), 64'h1);
    check("t1_rpt_vec", 64'(bus.rpt_vec), 64'h0002);
    check("t1_rpt_off", 64'(bus.rpt_offset), 64'(exp_off(32'd1)));
    bus.rpt_ready = 1; step(); bus.rpt_ready = 0;

    // 2: SOD only on the first symbol
    do_clear();
    send(8'h10); send(8'h05);
    check("t2_no_rpt", 64'(bus.rpt_valid), 64'h0);
    check("t2_active", 64'(active), 64'h0000);
    do_clear();
    send(8'h05); send(8'h10);
    check("t2_rpt_off", 64'(bus.rpt_offset), 64'(exp_off(32'd1)));
    check("t2_rpt_valid", 64'(bus.rpt_valid), 64'h1);
    bus.rpt_ready = 1; step(); bus.rpt_ready = 0;

    // 3: fill the FIFO with S2 ALL_INPUT reports on 0xFF
    do_clear();
    run = 0;
    cfg_write(0, 8'hFF, 32'h0004);
    cfg_write(2, 0, 32'h0000_0021);
    cfg_write(3, 0, 32'h0006);
    run = 1;
    acc_cnt = 0;
    bus.sym_valid = 1; bus.symbol = 8'hFF;
    for (int k = 0; k < 10; k++) step();
    check("t3_acc8", 64'(acc_cnt), 64'd8);
    check("t3_ready0", 64'(bus.sym_ready), 64'h0);
    bus.rpt_ready = 1; step(); bus.rpt_ready = 0;
    step(); step();
    check("t3_acc9", 64'(acc_cnt), 64'd9);
    check("t3_drop0", 64'(rpt_drop), 64'h0);
    bus.sym_valid = 0; bus.rpt_ready = 1;
    for (int k = 0; k < 9; k++) step();
    bus.rpt_ready = 0;

    // 4: config writes while running are ignored
    cfg_write(3, 0, 32'h000F);
    do_clear();
    send(8'h05);
    check("t4_active", 64'(active), 64'h0001);
    check("t4_no_rpt", 64'(bus.rpt_valid), 64'h0);

    // 5: clear colliding with a reporting accept
    clear = 1; bus.sym_valid = 1; bus.symbol = 8'hFF;
    step();
    clear = 0; bus.sym_valid = 0;
    check("t5_active", 64'(active), 64'h0);
    check("t5_rpt_valid", 64'(bus.rpt_valid), 64'h0);
    check("t5_drop", 64'(rpt_drop), 64'h1);
    send(8'hFF);
    check("t5_off0", 64'(bus.rpt_offset), 64'(exp_off(32'd0)));
    bus.rpt_ready = 1; step(); bus.rpt_ready = 0;
    do_clear();

    // 6: async reset mid-stream with 3 queued entries
    send(8'hFF); send(8'hFF); send(8'hFF);
    bus.sym_valid = 1;
    #2 reset = 1;
    model_reset();
    #1;
    check("t6_rpt_valid", 64'(bus.rpt_valid), 64'h0);
    check("t6_active", 64'(active), 64'h0);
    @(negedge clk);
    reset = 0;
    compare_all();
    send(8'hFF); send(8'h05); send(8'h10);
    check("t6_no_rpt", 64'(bus.rpt_valid), 64'h0);

    // random configuration and traffic
    run = 0;
    for (int s = 0; s < 256; s++) cfg_write(0, s, $urandom & $urandom & $urandom);
    for (int r = 0; r < 16; r++) cfg_write(1, r, $urandom & $urandom);
    cfg_write(1, $urandom_range(16, 255), 32'hFFFF_FFFF);
    cfg_write(2, 0, $urandom);
    cfg_write(3, 0, $urandom);
    for (int c = 0; c < 3000; c++) begin
      run = ($urandom_range(0, 19) != 0);
      clear = ($urandom_range(0, 59) == 0);
      bus.sym_valid = ($urandom_range(0, 3) != 0);
      bus.symbol = 8'($urandom_range(0, 31));
      bus.rpt_ready = ($urandom_range(0, 4) < 3);
      cfg_we = ($urandom_range(0, 39) == 0);
      cfg_kind = 2'($urandom_range(0, 3));
      cfg_index = 8'($urandom_range(0, 31));
      cfg_data = $urandom & $urandom;
      step();
    end
    clear = 0; cfg_we = 0; bus.sym_valid = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
